aes128_iter_core: RTL and testbench
===================================

Name: aes128_iter_core

Overview:
- Iterative, one-round-per-cycle AES-128 encryption engine with parametrised input bus width, loadable key and a valid/ready load handshake.
- Next generation of the fixed 64-bit, fixed-key, fully unrolled pipeline: about one tenth of the round logic, runtime key load, explicit busy/done signalling.
- Sits behind the AXI-lite register wrapper in the IP; the wrapper streams block and key beats in and reads the ciphertext back.

Parameters:
- BUS_W, 64, load-bus width; legal values 32, 64, 128; BEATS = 128/BUS_W.
- KEY_RESET, 128'h11111111111111111111111111111111, key value after reset.

Ports:
- clk  in  1  rising-edge clock
- reset_in  in  1  synchronous, active-high reset
- din  in  BUS_W  load data beat
- din_valid  in  1  beat present on din
- din_sel  in  1  0 = plaintext beat, 1 = key beat
- din_ready  out  1  beat accepted when din_valid & din_ready
- busy  out  1  encryption in progress
- dout  out  128  ciphertext, FIPS-197 byte 0 at [127:120]
- dout_valid  out  1  one-cycle pulse, dout newly updated

Behaviour:
- Reset values: din_ready=1, busy=0, dout=0, dout_valid=0, key=KEY_RESET, both beat counters=0, FSM=IDLE, staging registers=0. Reset mid-encryption aborts the block; no dout_valid.
- Beat order: beat k of a 128-bit word lands in bits [k*BUS_W +: BUS_W]. Beat 0 goes to the LSBs, matching the legacy low-half-first order.
- Plaintext beats go to a state staging register; pt_cnt counts 0..BEATS-1 and wraps to 0 on the last beat.
- Key beats go to a key staging register; key_cnt counts 0..BEATS-1. The active key is replaced by the staging register only when the last key beat is accepted. A partial key load never changes the active key.
- din_ready = (FSM==IDLE). While busy, all beats are refused and the counters hold.
- FSM:
  - IDLE: on acceptance of the last plaintext beat -> INIT.
  - INIT (1 cycle): s <= state ^ key; rk <= key; rnd <= 1 -> ROUND.
  - ROUND: s <= MixColumns(ShiftRows(SubBytes(s))) ^ next_rk; rk <= next_rk; rnd++. When rnd==9 -> FINAL.
  - FINAL: s <= ShiftRows(SubBytes(s)) ^ next_rk; dout <= that value; dout_valid <= 1 -> IDLE.
- next_rk = key_step(rk, RCON[rnd]). RCON sequence: 01 02 04 08 10 20 40 80 1b 36.
- Latency: last plaintext beat accepted at edge T; dout_valid is high for the cycle after edge T+11 (INIT + 9 ROUND + FINAL). busy=1 from after edge T through edge T+11.
- Back-to-back: din_ready rises in the same cycle as dout_valid, so the next block's first beat can be accepted in that cycle. Throughput is one block per 11+BEATS cycles.
- Key and plaintext interleaving is allowed in IDLE. A key completed before the last plaintext beat is used by that block.
- Simultaneous din_valid and reset_in: reset wins; the beat is dropped.
- dout holds its value until the next FINAL or reset.

Decomposition:
- Package aes_pkg:
  - constants NR=10, BLOCK_W=128;
  - RCON array;
  - FSM state enum {IDLE, INIT, ROUND, FINAL};
  - functions sbox(byte), xtime, sub_bytes, shift_rows, mix_columns.
- Sub-module aes_key_step_128: purely combinational key-expansion step, inputs rk[127:0] and rcon[7:0], output next_rk[127:0]. Unlike the legacy expander it has no register skew.
- Round datapath stays inline in the core and uses the package functions.

Test Plan:
- FIPS-197 App. B, BUS_W=64: key beats 0xabf7158809cf4f3c, then 0x2b7e151628aed2a6; plaintext beats 0x313198a2e0370734, then 0x3243f6a8885a308d -> after 11 cycles dout=3925841d02dc09fbdc118597196a0b32, single-cycle dout_valid.
- App. C.1 at BUS_W=32 and BUS_W=128: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> dout=69c4e0d86a7b0430d8cdb78070b4c55a at all widths.
- No key load after reset, plaintext all zeros -> dout equals the software-model result for key 1111...11. Then load the C.1 key with only 1 of 2 beats (BUS_W=64) and rerun -> result is unchanged.
- Assert din_valid on both din_sel values during busy -> din_ready=0, counters and staging unchanged, ciphertext correct. Second block sent immediately after dout_valid -> its latency is also 11 cycles.
- Assert reset_in at rnd=5 -> next cycle busy=0, dout=0, din_ready=1, key=KEY_RESET, and no dout_valid ever appears for the aborted block.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level round functions.
// Byte n of a 128-bit block (FIPS-197 order) lives at [127-8n -: 8]; n = row + 4*col.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    localparam logic [7:0] RCON [1:NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL
    } state_t;

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step_128.sv
// One AES-128 key-expansion step: round key i -> round key i+1, purely combinational.
module aes_key_step_128
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] next_rk
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the leading byte
    assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: beat-wise plaintext/key load, one round per clock,
// ciphertext presented on dout with a single-cycle dout_valid.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int           BUS_W     = 64,
    parameter logic [127:0] KEY_RESET = 128'h11111111111111111111111111111111
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [BUS_W-1:0] din,
    input  logic             din_valid,
    input  logic             din_sel,
    output logic             din_ready,
    output logic             busy,
    output logic [127:0]     dout,
    output logic             dout_valid
);

    localparam int                BEATS     = BLOCK_W / BUS_W;
    localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    state_t             state, state_nxt;
    logic [127:0]       s, rk, key;
    logic [127:0]       pt_stage, key_stage;
    logic [127:0]       pt_merge, key_merge;
    logic [127:0]       next_rk, round_out, final_out;
    logic [3:0]         rnd;
    logic [7:0]         rcon;
    logic [CNT_W-1:0]   pt_cnt, key_cnt;
    logic               accept, pt_acc, key_acc, pt_last, key_last;

    assign din_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = din_valid && din_ready;
    assign pt_acc    = accept && !din_sel;
    assign key_acc   = accept && din_sel;
    assign pt_last   = pt_acc && (pt_cnt == LAST_BEAT);
    assign key_last  = key_acc && (key_cnt == LAST_BEAT);

    // Staging words with the current beat spliced in; used both for the
    // staging update and for the key commit on the final key beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pt_merge  = pt_stage;
        key_merge = key_stage;
        pt_merge[int'(pt_cnt) * BUS_W +: BUS_W]   = din;
        key_merge[int'(key_cnt) * BUS_W +: BUS_W] = din;
    end

    always_comb begin
        rcon = 8'h00;
        if (rnd != 4'd0 && rnd <= 4'(NR)) begin
            rcon = RCON[rnd];
        end
    end

    aes_key_step_128 u_key_step (
        .rk      (rk),
        .rcon    (rcon),
        .next_rk (next_rk)
    );

    assign round_out = mix_columns(shift_rows(sub_bytes(s))) ^ next_rk;
    assign final_out = shift_rows(sub_bytes(s)) ^ next_rk;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pt_last) state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   if (rnd == 4'(NR - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            s          <= '0;
            rk         <= '0;
            rnd        <= '0;
            key        <= KEY_RESET;
            pt_stage   <= '0;
            key_stage  <= '0;
            pt_cnt     <= '0;
            key_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;

            if (pt_acc) begin
                pt_stage <= pt_merge;
                pt_cnt   <= pt_last ? '0 : pt_cnt + 1'b1;
            end

            // A partial key load only touches staging; the active key moves on the last beat.
            if (key_acc) begin
                key_stage <= key_merge;
                key_cnt   <= key_last ? '0 : key_cnt + 1'b1;
                if (key_last) begin
                    key <= key_merge;
                end
            end

            case (state)
                INIT: begin
                    s   <= pt_stage ^ key;
                    rk  <= key;
                    rnd <= 4'd1;
                end
                ROUND: begin
                    s   <= round_out;
                    rk  <= next_rk;
                    rnd <= rnd + 4'd1;
                end
                FINAL: begin
                    s          <= final_out;
                    rk         <= next_rk;
                    dout       <= final_out;
                    dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core: a GF(2^8)-arithmetic AES model predicts each
// ciphertext and its completion cycle; monitors compare whenever dout_valid fires.
module tb_aes128_iter_core;

    localparam logic [127:0] KEY_RST = 128'h11111111111111111111111111111111;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset_in;
    logic [63:0]   din;
    logic          din_valid, din_sel, din_ready, busy, dout_valid;
    logic [127:0]  dout;

    logic [31:0]   din32;
    logic          v32, sel32, rdy32, busy32, dv32;
    logic [127:0]  dout32;
    logic [127:0]  din128;
    logic          v128, sel128, rdy128, busy128, dv128;
    logic [127:0]  dout128;

    aes128_iter_core #(.BUS_W(64)) dut (
        .clk(clk), .reset_in(reset_in), .din(din), .din_valid(din_valid), .din_sel(din_sel),
        .din_ready(din_ready), .busy(busy), .dout(dout), .dout_valid(dout_valid)
    );

    aes128_iter_core #(.BUS_W(32)) dut32 (
        .clk(clk), .reset_in(reset_in), .din(din32), .din_valid(v32), .din_sel(sel32),
        .din_ready(rdy32), .busy(busy32), .dout(dout32), .dout_valid(dv32)
    );

    aes128_iter_core #(.BUS_W(128)) dut128 (
        .clk(clk), .reset_in(reset_in), .din(din128), .din_valid(v128), .din_sel(sel128),
        .din_ready(rdy128), .busy(busy128), .dout(dout128), .dout_valid(dv128)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int i = 1; i < 256; i++) begin
                if (gmul(8'(x), 8'(i)) == 8'h01) inv = 8'(i);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] mix_coef(input int row, input int j);
        case ((j - row + 4) % 4)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, acc;
        logic [31:0]  tmp;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]] ^ rc, sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) begin
            tmp   = w[n/4];
            st[n] = pt[127 - 8*n -: 8] ^ tmp[31 - 8*(n%4) -: 8];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) st[n] = sb[st[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = st[row + 4*((c + row) % 4)];
            for (int n = 0; n < 16; n++) st[n] = t[n];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc ^= gmul(st[4*c + j], mix_coef(row, j));
                        t[4*c + row] = acc;
                    end
                for (int n = 0; n < 16; n++) st[n] = t[n];
            end
            for (int n = 0; n < 16; n++) begin
                tmp   = w[4*r + n/4];
                st[n] = st[n] ^ tmp[31 - 8*(n%4) -: 8];
            end
        end
        for (int n = 0; n < 16; n++) ct[127 - 8*n -: 8] = st[n];
        return ct;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int           expcyc_q [$];
    logic [127:0] exp32_q [$];
    int           expcyc32_q [$];
    logic [127:0] exp128_q [$];
    int           expcyc128_q [$];

    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dout_valid got=%h required=no_output", dout);
            end else begin
                check("dout64", dout, exp_q.pop_front());
                check("latency64", 128'(cyc), 128'(expcyc_q.pop_front()));
            end
        end
        if (dv32) begin
            if (exp32_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dout_valid32 got=%h required=no_output", dout32);
            end else begin
                check("dout32", dout32, exp32_q.pop_front());
                check("latency32", 128'(cyc), 128'(expcyc32_q.pop_front()));
            end
        end
        if (dv128) begin
            if (exp128_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dout_valid128 got=%h required=no_output", dout128);
            end else begin
                check("dout128", dout128, exp128_q.pop_front());
                check("latency128", 128'(cyc), 128'(expcyc128_q.pop_front()));
            end
        end
    end

    // ---------------- 64-bit stimulus ----------------
    logic [127:0] ref_key;
    logic [63:0]  kq [$];
    logic [63:0]  pq [$];
    int           last_acc;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic sel, input logic [63:0] d);
        int n;
        n = 0;
        din = d; din_sel = sel; din_valid = 1'b1;
        while (!din_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("din_ready_wait", din_ready, 1'b1);
        last_acc = cyc;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic key_beat(input logic [63:0] d);
        send_beat(1'b1, d);
        kq.push_back(d);
        if (kq.size() == 2) begin
            ref_key = {kq[1], kq[0]};
            kq.delete();
        end
    endtask

    task automatic pt_beat(input logic [63:0] d, input bit push_exp = 1'b1,
                           input bit use_const = 1'b0, input logic [127:0] const_exp = '0);
        logic [127:0] pt;
        send_beat(1'b0, d);
        pq.push_back(d);
        if (pq.size() == 2) begin
            pt = {pq[1], pq[0]};
            pq.delete();
            if (push_exp) begin
                exp_q.push_back(use_const ? const_exp : aes_ref(ref_key, pt));
                expcyc_q.push_back(last_acc + 12);
            end
        end
    endtask

    task automatic busy_noise(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din_sel   = 1'($urandom_range(0, 1));
            din       = {$urandom, $urandom};
            check("busy_din_ready", din_ready, 1'b0);
            check("busy_flag", busy, 1'b1);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain64", 128'(exp_q.size()), 128'd0);
        check("idle_after_done", busy, 1'b0);
    endtask

    bit rst_released = 1'b0;
    bit side_done    = 1'b0;

    initial begin : main_seq
        logic [127:0] p;
        int           blk_acc, nk, n;
        reset_in = 1'b1; din = '0; din_valid = 1'b0; din_sel = 1'b0;
        ref_key = KEY_RST;
        build_sbox();
        repeat (3) @(negedge clk);
        check("rst_din_ready", din_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_dout_valid", dout_valid, 1'b0);
        reset_in = 1'b0;
        rst_released = 1'b1;

        // Reset key, zero plaintext; then a half key load must not disturb it
        pt_beat(64'h0); pt_beat(64'h0); drain();
        key_beat(C1_KEY[63:0]);
        pt_beat(64'h0); pt_beat(64'h0); drain();

        // Completing that load yields the C.1 key
        key_beat(C1_KEY[127:64]);
        pt_beat(C1_PT[63:0]); pt_beat(C1_PT[127:64], 1'b1, 1'b1, C1_CT); drain();

        // App. B with key and plaintext beats interleaved, noise while busy, back-to-back block
        key_beat(64'habf7158809cf4f3c);
        pt_beat(64'h313198a2e0370734);
        key_beat(64'h2b7e151628aed2a6);
        pt_beat(64'h3243f6a8885a308d, 1'b1, 1'b1, B_CT);
        blk_acc = last_acc;
        busy_noise(8);
        p = {$urandom, $urandom, $urandom, $urandom};
        pt_beat(p[63:0]);
        check("b2b_first_beat_cycle", 128'(last_acc), 128'(blk_acc + 12));
        pt_beat(p[127:64]);
        drain();

        // Randomized blocks with random key loads (full, partial, interleaved)
        for (int b = 0; b < 16; b++) begin
            nk = $urandom_range(0, 2);
            p  = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < nk; k++) key_beat({$urandom, $urandom});
            pt_beat(p[63:0]);
            if ($urandom_range(0, 3) == 0) key_beat({$urandom, $urandom});
            pt_beat(p[127:64]);
            if ($urandom_range(0, 1) == 1) busy_noise($urandom_range(1, 9));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        n = 0;
        while (!side_done && n < 500) begin
            @(negedge clk);
            n++;
        end

        // Abort mid-encryption at rnd=5
        key_beat({$urandom, $urandom});
        p = {$urandom, $urandom, $urandom, $urandom};
        pt_beat(p[63:0]);
        pt_beat(p[127:64], 1'b0);
        repeat (5) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        reset_in = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_dout", dout, '0);
        check("abort_din_ready", din_ready, 1'b1);
        check("abort_dout_valid", dout_valid, 1'b0);
        reset_in = 1'b0;
        kq.delete(); pq.delete();
        ref_key = KEY_RST;
        repeat (20) @(negedge clk);
        pt_beat(64'h0); pt_beat(64'h0); drain();
        key_beat({$urandom, $urandom}); key_beat({$urandom, $urandom});
        p = {$urandom, $urandom, $urandom, $urandom};
        pt_beat(p[63:0]); pt_beat(p[127:64]); drain();

        repeat (5) @(negedge clk);
        check("drain32", 128'(exp32_q.size()), 128'd0);
        check("drain128", 128'(exp128_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- 32- and 128-bit instances: C.1 vector ----------------
    initial begin : side_seq
        din32 = '0; v32 = 1'b0; sel32 = 1'b0;
        din128 = '0; v128 = 1'b0; sel128 = 1'b0;
        wait (rst_released);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel32 = 1'b1; din32 = C1_KEY[32*k +: 32]; v32 = 1'b1;
            check("rdy32_key", rdy32, 1'b1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            sel32 = 1'b0; din32 = C1_PT[32*k +: 32]; v32 = 1'b1;
            check("rdy32_pt", rdy32, 1'b1);
            if (k == 3) begin
                exp32_q.push_back(C1_CT);
                expcyc32_q.push_back(cyc + 12);
            end
            @(negedge clk);
        end
        v32 = 1'b0;

        sel128 = 1'b1; din128 = C1_KEY; v128 = 1'b1;
        check("rdy128_key", rdy128, 1'b1);
        @(negedge clk);
        sel128 = 1'b0; din128 = C1_PT;
        check("rdy128_pt", rdy128, 1'b1);
        exp128_q.push_back(C1_CT);
        expcyc128_q.push_back(cyc + 12);
        @(negedge clk);
        v128 = 1'b0;
        repeat (30) @(negedge clk);
        side_done = 1'b1;
    end

endmodule
